// File: rtl/iic_pkg.sv
// -----------------------------------------------------------------------------
// iic_pkg
// Shared definitions for the I2C single-register write arbiter:
//   - iic_state_e    : 2-bit arbiter state encoding (also exported for debug)
//   - SLAVE_W/REG_W/DATA_W : command field widths
//   - IIC_WRITE      : R/W bit value for a write on the wire
//   - GAP_CYCLES_200MHZ : default bus-free gap (5 us at 200 MHz)
// -----------------------------------------------------------------------------
package iic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } iic_state_e;

  localparam int   SLAVE_W           = 7;
  localparam int   REG_W             = 8;
  localparam int   DATA_W            = 8;
  localparam logic IIC_WRITE         = 1'b0;
  localparam int   GAP_CYCLES_200MHZ = 1000;

  // Address byte as it appears on the bus for a write to 'slave'.
  function automatic logic [SLAVE_W:0] iic_addr_byte(input logic [SLAVE_W-1:0] slave);
    return {slave, IIC_WRITE};
  endfunction

endpackage

// File: rtl/iic_write_arbiter_if.sv
// -----------------------------------------------------------------------------
// iic_write_arbiter_if
// Bundles both requester ports, the engine command port and the status
// outputs of the write arbiter.
//
// Handshake rules (both sides):
//   - ReqNValid is held, with its fields stable, until ReqNReady pulses; the
//     request is accepted in the cycle ReqNReady is high.
//   - CmdValid is held, with CmdSlave/CmdReg/CmdData stable, until the engine
//     raises CmdReady; the command transfers on the edge with both high.
//   - CmdDone is a one-cycle pulse; CmdNack is meaningful only with CmdDone.
//   - ReqNDone is a one-cycle pulse; ReqNErr is meaningful only with ReqNDone.
//
// Modports:
//   master : the arbiter itself
//   slave  : requesters + engine (the environment around the arbiter)
// -----------------------------------------------------------------------------
interface iic_write_arbiter_if;
  import iic_pkg::*;

  logic               Req0Valid, Req1Valid;
  logic [SLAVE_W-1:0] Req0Slave, Req1Slave;
  logic [REG_W-1:0]   Req0Reg,   Req1Reg;
  logic [DATA_W-1:0]  Req0Data,  Req1Data;
  logic               Req0Ready, Req1Ready;
  logic               Req0Done,  Req1Done;
  logic               Req0Err,   Req1Err;

  logic               CmdValid;
  logic [SLAVE_W-1:0] CmdSlave;
  logic [REG_W-1:0]   CmdReg;
  logic [DATA_W-1:0]  CmdData;
  logic               CmdReady;
  logic               CmdDone;
  logic               CmdNack;

  logic               Busy;
  logic               Owner;

  modport master (
    input  Req0Valid, Req1Valid, Req0Slave, Req1Slave, Req0Reg, Req1Reg,
           Req0Data, Req1Data,
    output Req0Ready, Req1Ready, Req0Done, Req1Done, Req0Err, Req1Err,
    output CmdValid, CmdSlave, CmdReg, CmdData,
    input  CmdReady, CmdDone, CmdNack,
    output Busy, Owner
  );

  modport slave (
    output Req0Valid, Req1Valid, Req0Slave, Req1Slave, Req0Reg, Req1Reg,
           Req0Data, Req1Data,
    input  Req0Ready, Req1Ready, Req0Done, Req1Done, Req0Err, Req1Err,
    input  CmdValid, CmdSlave, CmdReg, CmdData,
    output CmdReady, CmdDone, CmdNack,
    input  Busy, Owner
  );

endinterface

// File: rtl/iic_write_arbiter.sv
// -----------------------------------------------------------------------------
// iic_write_arbiter
// Shares one single-register I2C write engine between two requesters
// (port 0: boot configuration sequencer, port 1: runtime mode writer).
// Requests are granted round-robin, held in command registers while the
// engine runs, and separated by a programmable bus-free gap. Completion and
// NACK status go back to the owning port.
//
// Ports:
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : iic_write_arbiter_if.master (requests, engine command, status)
//   dbg_state  : current FSM state, for observation only
//
// Parameters:
//   GAP_CYCLES : idle cycles between engine transactions
//   GAP_MSB    : MSB of the gap counter, 2^(GAP_MSB+1) > GAP_CYCLES
//   RETRY_MAX  : total attempts per request when retry is built (1..7)
//
// Build option: define IIC_ARB_RETRY_EN to re-issue a NACKed command after
// the gap, up to RETRY_MAX attempts in total. Without it, a NACK completes
// the request immediately with Err=1.
// -----------------------------------------------------------------------------
module iic_write_arbiter
  import iic_pkg::*;
#(
  parameter int GAP_CYCLES = GAP_CYCLES_200MHZ,
  parameter int GAP_MSB    = 11,
  parameter int RETRY_MAX  = 3
) (
  input  logic                Clk,
  input  logic                Reset,
  iic_write_arbiter_if.master bus,
  output iic_state_e          dbg_state
);

  localparam logic [GAP_MSB:0] GAP_LAST = (GAP_MSB + 1)'(GAP_CYCLES - 1);

  // Elaboration-time guard on parameter ranges.
  if ((GAP_CYCLES < 1) || ((1 << (GAP_MSB + 1)) <= GAP_CYCLES) ||
      (RETRY_MAX < 1) || (RETRY_MAX > 7)) begin : g_bad_param
    $error("iic_write_arbiter: illegal GAP_CYCLES/GAP_MSB/RETRY_MAX");
  end

  iic_state_e         state_q, state_d;
  logic               owner_q, owner_d;
  logic [1:0]         ready_q, ready_d;
  logic [1:0]         done_q,  done_d;
  logic [1:0]         err_q,   err_d;
  logic [SLAVE_W-1:0] cmd_slave_q, cmd_slave_d;
  logic [REG_W-1:0]   cmd_reg_q,   cmd_reg_d;
  logic [DATA_W-1:0]  cmd_data_q,  cmd_data_d;
  logic [GAP_MSB:0]   gap_cnt_q,   gap_cnt_d;
  logic               sel;
`ifdef IIC_ARB_RETRY_EN
  logic [2:0]         attempt_q, attempt_d;   // attempts already NACKed
  logic               retry_q,   retry_d;     // re-issue pending after GAP
`endif

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b1;
      ready_q     <= '0;
      done_q      <= '0;
      err_q       <= '0;
      cmd_slave_q <= '0;
      cmd_reg_q   <= '0;
      cmd_data_q  <= '0;
      gap_cnt_q   <= '0;
`ifdef IIC_ARB_RETRY_EN
      attempt_q   <= '0;
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cmd_slave_q <= cmd_slave_d;
      cmd_reg_q   <= cmd_reg_d;
      cmd_data_q  <= cmd_data_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef IIC_ARB_RETRY_EN
      attempt_q   <= attempt_d;
      retry_q     <= retry_d;
`endif
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ready_d     = '0;
    done_d      = '0;
    err_d       = '0;
    cmd_slave_d = cmd_slave_q;
    cmd_reg_d   = cmd_reg_q;
    cmd_data_d  = cmd_data_q;
    gap_cnt_d   = gap_cnt_q;
    sel         = 1'b0;
`ifdef IIC_ARB_RETRY_EN
    attempt_d   = attempt_q;
    retry_d     = retry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.Req0Valid || bus.Req1Valid) begin
          // On a tie the port that did not win last time goes next.
          sel = (bus.Req0Valid && bus.Req1Valid) ? ~owner_q : bus.Req1Valid;
          owner_d      = sel;
          ready_d[sel] = 1'b1;
          cmd_slave_d  = sel ? bus.Req1Slave : bus.Req0Slave;
          cmd_reg_d    = sel ? bus.Req1Reg   : bus.Req0Reg;
          cmd_data_d   = sel ? bus.Req1Data  : bus.Req0Data;
          state_d      = ST_ISSUE;
`ifdef IIC_ARB_RETRY_EN
          attempt_d    = '0;
          retry_d      = 1'b0;
`endif
        end
      end
      ST_ISSUE: begin
        if (bus.CmdReady) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.CmdDone) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
          if (!bus.CmdNack) begin
            done_d[owner_q] = 1'b1;
          end else begin
`ifdef IIC_ARB_RETRY_EN
            if (attempt_q < 3'(RETRY_MAX - 1)) begin
              attempt_d = attempt_q + 3'd1;
              retry_d   = 1'b1;
            end else begin
              done_d[owner_q] = 1'b1;
              err_d[owner_q]  = 1'b1;
            end
`else
            done_d[owner_q] = 1'b1;
            err_d[owner_q]  = 1'b1;
`endif
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
`ifdef IIC_ARB_RETRY_EN
          // A retry goes straight back to the engine with the held command.
          state_d   = retry_q ? ST_ISSUE : ST_IDLE;
          retry_d   = 1'b0;
`else
          state_d   = ST_IDLE;
`endif
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.CmdValid  = (state_q == ST_ISSUE);
    bus.Busy      = (state_q != ST_IDLE);
    bus.Owner     = owner_q;
    bus.CmdSlave  = cmd_slave_q;
    bus.CmdReg    = cmd_reg_q;
    bus.CmdData   = cmd_data_q;
    bus.Req0Ready = ready_q[0];
    bus.Req1Ready = ready_q[1];
    bus.Req0Done  = done_q[0];
    bus.Req1Done  = done_q[1];
    bus.Req0Err   = err_q[0];
    bus.Req1Err   = err_q[1];
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_iic_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_iic_write_arbiter
// Self-checking bench for iic_write_arbiter. A transaction-level model builds
// the expected stream of engine commands (round-robin between ports with
// pending work, retries per NACK rule) into exp_q; an engine model in the
// bench consumes it and checks fields, owner, Done/Err and command spacing.
// Compile with +define+IIC_ARB_RETRY_EN to exercise the retry build.
// -----------------------------------------------------------------------------
module tb_iic_write_arbiter;
  import iic_pkg::*;

  localparam int GAP = 40;
`ifdef IIC_ARB_RETRY_EN
  localparam int RETRY_EFF = 3;
`else
  localparam int RETRY_EFF = 1;
`endif

  typedef struct packed {
    logic       port;
    logic [6:0] slave;
    logic [7:0] rg;
    logic [7:0] data;
    logic       nack;
    logic       fin;
  } hs_t;

  // ---------------- clock / reset ----------------
  logic       Clk;
  logic       Reset;
  iic_state_e dbg_state;
  int         cyc;

  iic_write_arbiter_if bus();

  iic_write_arbiter #(
    .GAP_CYCLES(GAP),
    .GAP_MSB   (5),
    .RETRY_MAX (3)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus.master),
    .dbg_state(dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [25:0] exp_q[$];
  logic [22:0] q0[$];
  logic [22:0] q1[$];
  logic        model_owner;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    Reset         = 1'b1;
    bus.Req0Valid = 1'b0; bus.Req0Slave = '0; bus.Req0Reg = '0; bus.Req0Data = '0;
    bus.Req1Valid = 1'b0; bus.Req1Slave = '0; bus.Req1Reg = '0; bus.Req1Data = '0;
    bus.CmdReady  = 1'b0; bus.CmdDone = 1'b0; bus.CmdNack = 1'b0;
    repeat (3) @(negedge Clk);
    Reset       = 1'b0;
    model_owner = 1'b1;
  endtask

  task automatic drive_reqs();
    bus.Req0Valid = (q0.size() != 0);
    if (q0.size() != 0) {bus.Req0Slave, bus.Req0Reg, bus.Req0Data} = q0[0];
    else {bus.Req0Slave, bus.Req0Reg, bus.Req0Data} = '0;
    bus.Req1Valid = (q1.size() != 0);
    if (q1.size() != 0) {bus.Req1Slave, bus.Req1Reg, bus.Req1Data} = q1[0];
    else {bus.Req1Slave, bus.Req1Reg, bus.Req1Data} = '0;
  endtask

  task automatic check_reset_outputs(input string p);
    check_eq({p, "_cmd_valid"}, bus.CmdValid, 0);
    check_eq({p, "_busy"},      bus.Busy, 0);
    check_eq({p, "_owner"},     bus.Owner, 1);
    check_eq({p, "_ready"},     {bus.Req0Ready, bus.Req1Ready}, 0);
    check_eq({p, "_done"},      {bus.Req0Done, bus.Req1Done}, 0);
    check_eq({p, "_err"},       {bus.Req0Err, bus.Req1Err}, 0);
    check_eq({p, "_cmd_fields"}, {bus.CmdSlave, bus.CmdReg, bus.CmdData}, 0);
    check_eq({p, "_state"},     dbg_state, ST_IDLE);
  endtask

  // Queues n0/n1 random requests, predicts the command stream, then plays
  // requesters and engine cycle by cycle until everything has drained.
  task automatic run_traffic(input int n0, input int n1, input bit nack_all);
    hs_t         h, cur;
    logic [22:0] r;
    logic        p;
    int          i0, i1, ph, dly, hs_seen, hs_exp, last_done_cyc;
    bit          done_due, done_err_exp, done_port_exp, first_cmd, last_fin, prev_cv, drained;

    q0.delete(); q1.delete(); exp_q.delete();
    for (int i = 0; i < n0; i++) q0.push_back(23'($urandom));
    for (int i = 0; i < n1; i++) q1.push_back(23'($urandom));

    // Reference model: round-robin among ports that still have work.
    i0 = 0; i1 = 0;
    while (i0 < n0 || i1 < n1) begin
      if (i0 < n0 && i1 < n1) p = ~model_owner;
      else p = (i1 < n1);
      model_owner = p;
      if (p) begin r = q1[i1]; i1++; end
      else   begin r = q0[i0]; i0++; end
      for (int a = 0; a < RETRY_EFF; a++) begin
        h.port = p;
        {h.slave, h.rg, h.data} = r;
        h.nack = nack_all ? 1'b1 : ($urandom_range(0, 3) == 0);
        h.fin  = !h.nack || (a == RETRY_EFF - 1);
        exp_q.push_back(h);
        if (h.fin) break;
      end
    end

    hs_exp = exp_q.size(); hs_seen = 0;
    ph = 0; dly = 0; done_due = 0; done_err_exp = 0; done_port_exp = 0;
    first_cmd = 1; last_fin = 1; last_done_cyc = 0; prev_cv = 0; drained = 0;
    cur = '0;
    drive_reqs();

    for (int c = 0; c < 20000; c++) begin
      @(negedge Clk);
      check_eq("req0_done", bus.Req0Done, done_due && !done_port_exp);
      check_eq("req1_done", bus.Req1Done, done_due && done_port_exp);
      if (done_due) begin
        if (done_port_exp) check_eq("req1_err", bus.Req1Err, done_err_exp);
        else               check_eq("req0_err", bus.Req0Err, done_err_exp);
      end
      done_due = 0;

      if (bus.Req0Ready) begin
        check_eq("req0_ready_valid", bus.Req0Valid, 1);
        check_eq("req0_ready_cmd", bus.CmdValid, 1);
        if (q0.size() != 0) void'(q0.pop_front());
      end
      if (bus.Req1Ready) begin
        check_eq("req1_ready_valid", bus.Req1Valid, 1);
        check_eq("req1_ready_cmd", bus.CmdValid, 1);
        if (q1.size() != 0) void'(q1.pop_front());
      end
      drive_reqs();

      if (bus.CmdValid && !prev_cv) begin
        if (!first_cmd)
          check_eq("cmd_spacing", cyc - last_done_cyc, last_fin ? GAP + 2 : GAP + 1);
        first_cmd = 0;
      end
      prev_cv = bus.CmdValid;

      // Engine model
      bus.CmdReady = 1'b0; bus.CmdDone = 1'b0; bus.CmdNack = 1'b0;
      case (ph)
        0: begin
          if (bus.CmdValid) begin
            dly = $urandom_range(0, 3);
            ph  = 1;
          end else if ($urandom_range(0, 7) == 0) begin
            bus.CmdDone = 1'b1;                     // stray pulse, must be ignored
            bus.CmdNack = 1'($urandom_range(0, 1));
          end
        end
        1: begin
          if (dly == 0) begin
            if (exp_q.size() == 0) begin
              check_eq("cmd_unexpected", bus.CmdValid, 0);
              cur = '0; cur.fin = 1'b1;
            end else begin
              cur = exp_q.pop_front();
              check_eq("cmd_slave", bus.CmdSlave, cur.slave);
              check_eq("cmd_reg",   bus.CmdReg,   cur.rg);
              check_eq("cmd_data",  bus.CmdData,  cur.data);
              check_eq("owner",     bus.Owner,    cur.port);
              hs_seen++;
            end
            bus.CmdReady = 1'b1;
            ph = 2;
          end else begin
            dly--;
          end
        end
        2: begin
          check_eq("cmd_valid_drop", bus.CmdValid, 0);
          dly = $urandom_range(3, 20);
          ph  = 3;
        end
        default: begin
          if (dly == 0) begin
            bus.CmdDone   = 1'b1;
            bus.CmdNack   = cur.nack;
            last_done_cyc = cyc;
            last_fin      = cur.fin;
            done_due      = cur.fin;
            done_port_exp = cur.port;
            done_err_exp  = cur.nack;
            ph = 0;
          end else begin
            dly--;
            if ($urandom_range(0, 7) == 0) bus.CmdReady = 1'b1;  // stray, must be ignored
          end
        end
      endcase

      if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 && ph == 0 &&
          !done_due && !bus.Busy && !bus.CmdDone) begin
        drained = 1;
        break;
      end
    end
    check_eq("traffic_drained", drained, 1);
    check_eq("hs_count", hs_seen, hs_exp);
    check_eq("busy_idle", bus.Busy, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    check_reset_outputs("rst");

    // Directed single port-0 write, engine always ready, Done after ~100 cycles.
    bus.CmdReady  = 1'b1;
    bus.Req0Valid = 1'b1; bus.Req0Slave = 7'h4C; bus.Req0Reg = 8'h1E; bus.Req0Data = 8'hA4;
    @(negedge Clk);
    check_eq("t1_req0_ready", bus.Req0Ready, 1);
    check_eq("t1_req1_ready", bus.Req1Ready, 0);
    check_eq("t1_cmd_valid",  bus.CmdValid, 1);
    check_eq("t1_cmd_slave",  bus.CmdSlave, 8'h4C);
    check_eq("t1_cmd_reg",    bus.CmdReg, 8'h1E);
    check_eq("t1_cmd_data",   bus.CmdData, 8'hA4);
    check_eq("t1_owner",      bus.Owner, 0);
    check_eq("t1_busy",       bus.Busy, 1);
    bus.Req0Valid = 1'b0;
    @(negedge Clk);
    check_eq("t1_cmd_valid_low", bus.CmdValid, 0);
    check_eq("t1_ready_once",    bus.Req0Ready, 0);
    bus.CmdReady = 1'b0;
    repeat (98) @(negedge Clk);
    bus.CmdDone = 1'b1; bus.CmdNack = 1'b0;
    @(negedge Clk);
    bus.CmdDone = 1'b0;
    check_eq("t1_req0_done", bus.Req0Done, 1);
    check_eq("t1_req0_err",  bus.Req0Err, 0);
    check_eq("t1_req1_done", bus.Req1Done, 0);
    @(negedge Clk);
    check_eq("t1_done_pulse", bus.Req0Done, 0);
    repeat (GAP - 2) @(negedge Clk);
    check_eq("t1_busy_in_gap", bus.Busy, 1);
    @(negedge Clk);
    check_eq("t1_busy_fall", bus.Busy, 0);

    // Both ports loaded from reset, random NACKs.
    do_reset();
    run_traffic($urandom_range(3, 6), $urandom_range(3, 6), 1'b0);

    // One port-0 request with the engine NACKing every attempt.
    run_traffic(1, 0, 1'b1);

    // Reset while waiting for the engine, then a late CmdDone.
    do_reset();
    bus.Req0Valid = 1'b1; bus.Req0Slave = 7'h21; bus.Req0Reg = 8'h05; bus.Req0Data = 8'h3C;
    @(negedge Clk);
    bus.Req0Valid = 1'b0; bus.CmdReady = 1'b1;
    @(negedge Clk);
    bus.CmdReady = 1'b0;
    check_eq("t5_state_wait", dbg_state, ST_WAIT_DONE);
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0; bus.CmdDone = 1'b1; bus.CmdNack = 1'b0;
    check_reset_outputs("t5_rst");
    @(negedge Clk);
    bus.CmdDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t5_no_done", {bus.Req0Done, bus.Req1Done}, 0);
      check_eq("t5_busy",    bus.Busy, 0);
      @(negedge Clk);
    end
    model_owner = 1'b1;
    run_traffic(0, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iic_write_arbiter.md
# iic_write_arbiter

Shares one single-register I2C write engine between two requesters: the boot-time configuration sequencer (port 0) and the runtime mode-change writer (port 1). Each request is one {slave address, register address, data} write, accepted with a valid/ready handshake and issued to the engine. Requests are granted round-robin, and a programmable bus-free gap is enforced between transactions. Completion and NACK status are returned to the owning requester.

## Interface
- GAP_CYCLES, 1000: idle Clk cycles between engine transactions (5 us at 200 MHz).
- GAP_MSB, 11: MSB of the gap counter; must satisfy 2^(GAP_MSB+1) > GAP_CYCLES.
- RETRY_MAX, 3: total attempts per request when retry is compiled in (range 1..7).

Ports:
- Clk  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high.
- Req0Valid / Req1Valid  in  1  request pending; held with its fields until the matching Ready.
- Req0Slave / Req1Slave  in  7  7-bit slave address.
- Req0Reg / Req1Reg  in  8  register address.
- Req0Data / Req1Data  in  8  write data.
- Req0Ready / Req1Ready  out  1  one-cycle accept pulse.
- Req0Done / Req1Done  out  1  one-cycle completion pulse.
- Req0Err / Req1Err  out  1  valid only with Done; 1 = final NACK.
- CmdValid  out  1  command offered to the engine.
- CmdSlave  out  7, CmdReg  out  8, CmdData  out  8: command fields, stable while CmdValid is high.
- CmdReady  in  1  engine accepts the command on an edge where CmdValid & CmdReady.
- CmdDone  in  1  engine completion pulse.
- CmdNack  in  1  sampled only with CmdDone.
- Busy  out  1  high in every state except IDLE.
- Owner  out  1  index of the current or last granted port.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE
  - If any ReqNValid is high, select a port:
    - Only one valid: that port.
    - Both valid: the port != Owner (round-robin). After Reset, Owner=1, so port 0 wins the first tie.
  - The selected port's fields are registered into the command holding registers, Owner is updated, and the retry count is cleared.
  - ReqNReady pulses in the next cycle. Next state is ISSUE.
- ISSUE: CmdValid=1. On CmdValid & CmdReady, go to WAIT_DONE; CmdValid is low from the next cycle.
- WAIT_DONE: wait for CmdDone.
  - CmdNack=0: Done pulse with Err=0 to the Owner port, then GAP.
  - CmdNack=1: go to GAP, either with a final Done pulse with Err=1 or with a retry scheduled (see Configuration).
- GAP: counter runs 0..GAP_CYCLES-1. At GAP_CYCLES-1, go to ISSUE if a retry is pending, otherwise IDLE.
- Requests are sampled only in IDLE. Valid held through ISSUE/WAIT_DONE/GAP is neither accepted nor dropped.
- CmdDone outside WAIT_DONE is ignored. CmdReady outside ISSUE is ignored.
- Reset mid-transaction:
  - State goes to IDLE; all outputs 0; Owner=1; counters 0.
  - The in-flight request is abandoned with no Done pulse.
  - The engine shares Reset.

## Timing
- Reset values: CmdValid=0, ReqNReady=0, ReqNDone=0, ReqNErr=0, Busy=0, Owner=1, Cmd fields=0.
- Request accept: Valid sampled at edge k; Ready high during cycle k+1; CmdValid high from cycle k+1.
- Done/Err: CmdDone sampled at edge m; Done/Err high during cycle m+1 only.
- Minimum spacing between CmdValid assertions: GAP_CYCLES+1 cycles after CmdDone.
- Back-to-back request throughput is limited by the engine plus GAP. The arbiter itself adds 2 cycles per request (IDLE capture, then ISSUE).

## Configuration
- IIC_ARB_RETRY_EN defined:
  - A NACK with attempts < RETRY_MAX increments the attempt count, enters GAP, then re-issues the same held command. No Done pulse is given for that attempt.
  - A NACK on attempt RETRY_MAX gives Done with Err=1.
  - The attempt counter is 3 bits.
- Undefined: any NACK gives Done with Err=1 immediately; no retry counter is built.

## Structure
- Shared package iic_pkg holds:
  - State encodings (2-bit).
  - Field widths (SLAVE_W=7, REG_W=8, DATA_W=8).
  - IIC_WRITE=1'b0.
  - The default GAP_CYCLES at 200 MHz.
- No sub-module: the round-robin pick and the gap counter are inline. The write engine is instantiated by the parent, not inside this block.

## Test plan
- Single port-0 request {0x4C, 0x1E, 0xA4}, engine ready immediately, CmdDone after 100 cycles with Nack=0:
  - Req0Ready at k+1; CmdSlave=0x4C, CmdReg=0x1E, CmdData=0xA4.
  - Req0Done=1, Req0Err=0 one cycle after CmdDone.
  - Busy falls GAP_CYCLES cycles later.
- Both ports valid from reset, three requests each: grants alternate 0,1,0,1,0,1; every Done goes to the matching port.
- With IIC_ARB_RETRY_EN, RETRY_MAX=3, engine NACKs every attempt:
  - Exactly 3 CmdValid/CmdReady handshakes with identical fields, each separated by GAP.
  - One Req0Done with Err=1.
- Without the macro, one NACK: a single handshake and an immediate Done with Err=1.
- Reset asserted in WAIT_DONE, then CmdDone pulsed:
  - All outputs 0, Busy=0.
  - No Done pulse.
  - The next port-1 request is granted normally.
- Port 1 valid held while port 0's transaction is in GAP: Req1Ready is not seen until the cycle after GAP ends; CmdValid is never asserted during GAP.
